// File: rtl/ps2_scan_ctrl.sv
`timescale 1ns/1ps
// PS/2 keyboard receive controller: pin synchronisation, 11-bit framing with error checks,
// E0/F0 prefix folding, shift tracking and a show-ahead event FIFO with valid/ready.
module ps2_scan_ctrl #(
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_clk,
    input  logic             key_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_break,
    output logic             evt_ext,
    output logic             shift_held,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic             r_kc_s1, r_kc_s2, r_kc_prev, r_kd_s1, r_kd_s2;
    logic [1:0]       r_state, w_state_nxt;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [TW-1:0]    r_tcnt;
    logic [ERR_W-1:0] r_err;
    logic             r_strobe, r_busy;
    logic             r_ext_pend, r_brk_pend, r_shift_held, r_ovf;
    logic [9:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_cnt;

    logic w_fall, w_frame_done, w_frame_good, w_timeout, w_err_evt;
    logic w_is_e0, w_is_f0, w_push, w_pop, w_full, w_wr_en, w_valid;
    logic [9:0] w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kc_s1   <= 1'b1;
            r_kc_s2   <= 1'b1;
            r_kc_prev <= 1'b1;
            r_kd_s1   <= 1'b1;
            r_kd_s2   <= 1'b1;
        end else begin
            r_kc_s1   <= key_clk;
            r_kc_s2   <= r_kc_s1;
            r_kc_prev <= r_kc_s2;
            r_kd_s1   <= key_data;
            r_kd_s2   <= r_kd_s1;
        end
    end

    assign w_fall = r_kc_prev && !r_kc_s2;

    // Falls take priority over the timeout so a bit arriving on the last cycle still counts
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        w_frame_good = 1'b0;
        w_timeout    = 1'b0;
        if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_kd_s2) w_state_nxt = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_frame_done = 1'b1;
                    w_frame_good = r_kd_s2 && (^{r_shift, r_parity});
                    w_state_nxt  = S_IDLE;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end else if (r_state != S_IDLE && r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    assign w_err_evt = (w_frame_done && !w_frame_good) || w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_bitcnt <= 3'd0;
            r_tcnt   <= '0;
            r_err    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_strobe <= w_frame_done && w_frame_good;
            if (w_fall && r_state == S_IDLE)
                r_bitcnt <= 3'd0;
            else if (w_fall && r_state == S_DATA)
                r_bitcnt <= r_bitcnt + 3'd1;
            if (r_state == S_IDLE || w_fall || w_timeout)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + TW'(1);
            if (w_err_evt && r_err != {ERR_W{1'b1}})
                r_err <= r_err + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_fall && r_state == S_DATA)
            r_shift <= {r_kd_s2, r_shift[7:1]};
        if (w_fall && r_state == S_PARITY)
            r_parity <= r_kd_s2;
    end

    // Decode runs the cycle after the stop bit; r_shift is stable because the FSM is back in IDLE
    assign w_is_e0 = (r_shift == 8'hE0);
    assign w_is_f0 = (r_shift == 8'hF0);
    assign w_push  = r_strobe && !w_is_e0 && !w_is_f0;
    assign w_valid = (r_cnt != '0);
    assign w_pop   = w_valid && evt_ready;
    assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
            r_shift_held <= 1'b0;
            r_ovf        <= 1'b0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_cnt        <= '0;
        end else begin
            if (r_strobe) begin
                if (w_is_e0) begin
                    r_ext_pend <= 1'b1;
                end else if (w_is_f0) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end
            end
            if (w_push && (r_shift == 8'h12 || r_shift == 8'h59) && !r_ext_pend)
                r_shift_held <= !r_brk_pend;
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
            if (w_wr_en)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr] <= {r_brk_pend, r_ext_pend, r_shift};
    end

    // Storage is not reset, so the head is masked while the FIFO is empty
    assign w_head     = r_mem[r_rd] & {10{w_valid}};
    assign evt_valid  = w_valid;
    assign evt_code   = w_head[7:0];
    assign evt_ext    = w_head[8];
    assign evt_break  = w_head[9];
    assign shift_held = r_shift_held;
    assign overflow   = r_ovf;
    assign err_count  = r_err;
    assign busy       = r_busy;
endmodule

// File: tb/tb_ps2_scan_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for ps2_scan_ctrl: frame-level reference model feeds an expected-event
// queue; a monitor pops and compares every event the DUT hands over.
module tb_ps2_scan_ctrl;
    localparam int TC      = 100;
    localparam int DEPTH   = 4;
    localparam int EW      = 3;
    localparam int ERR_MAX = 7;
    localparam int HP      = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_clk = 1'b1;
    logic          key_data = 1'b1;
    logic          evt_valid, evt_ready = 1'b0;
    logic [7:0]    evt_code;
    logic          evt_break, evt_ext, shift_held, overflow, busy;
    logic          ovf_clr = 1'b0;
    logic [EW-1:0] err_count;

    int         n_chk = 0, n_fail = 0;
    logic [9:0] q[$];
    bit         m_ext = 0, m_brk = 0, m_shift = 0, m_ovf = 0;
    int         m_err = 0;
    bit         rnd_mode = 0;
    logic       ready_man = 1'b0;

    ps2_scan_ctrl #(.TIMEOUT_CYC(TC), .FIFO_DEPTH(DEPTH), .ERR_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .key_clk(key_clk), .key_data(key_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_break(evt_break), .evt_ext(evt_ext), .shift_held(shift_held),
        .overflow(overflow), .ovf_clr(ovf_clr), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Consumer handshake: manual level or random back-pressure
    initial forever begin
        @(posedge clk);
        #1;
        evt_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_man;
    end

    // Monitor: every accepted event must match the oldest expected one
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_evt: got 0x%0h expected none", {evt_break, evt_ext, evt_code});
            end else begin
                check("evt", {22'd0, evt_break, evt_ext, evt_code}, {22'd0, q.pop_front()});
            end
        end
    end

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            if (m_err < ERR_MAX) m_err++;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (q.size() >= DEPTH) m_ovf = 1;
            else q.push_back({m_brk, m_ext, b});
            if ((b == 8'h12 || b == 8'h59) && !m_ext) m_shift = !m_brk;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic drive_bit(input logic b);
        key_data = b;
        tick(HP);
        key_clk = 1'b0;
        tick(HP);
        key_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit chk_lat);
        logic par;
        par = ~(^b) ^ bad_par;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        key_data = !bad_stop;
        tick(HP);
        model_frame(b, !bad_par && !bad_stop);
        key_clk = 1'b0;
        if (chk_lat) begin
            repeat (4) @(negedge clk);
            check("lat_e1_valid", {31'd0, evt_valid}, 32'd0);
            @(negedge clk);
            check("lat_e2_valid", {31'd0, evt_valid}, 32'd1);
            tick(HP - 5);
        end else begin
            tick(HP);
        end
        key_clk = 1'b1;
        key_data = 1'b1;
        tick(HP);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_shift"}, {31'd0, shift_held}, {31'd0, m_shift});
        check({tag, "_err"}, {29'd0, err_count}, m_err);
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (q.size() != 0 && k < 400) begin
            tick(1);
            k++;
        end
        check({tag, "_drained"}, q.size(), 32'd0);
    endtask

    task automatic reset_dut();
        key_clk = 1'b1;
        key_data = 1'b1;
        rst_n = 1'b0;
        tick(3);
        q.delete();
        m_ext = 0; m_brk = 0; m_shift = 0; m_ovf = 0; m_err = 0;
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        bit bp, bs;
        tick(3);
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_code", {24'd0, evt_code}, 32'd0);
        check("rst_brk_ext", {30'd0, evt_break, evt_ext}, 32'd0);
        check("rst_shift", {31'd0, shift_held}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_err", {29'd0, err_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Reset in the middle of a frame
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        check("midframe_busy", {31'd0, busy}, 32'd1);
        reset_dut();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, evt_valid}, 32'd0);
        check("midrst_err", {29'd0, err_count}, 32'd0);
        ready_man = 1'b1;
        send_frame(8'h1C, 0, 0, 0);
        wait_drain("after_rst");
        check_state("after_rst");

        // Single make with exact latency, then pop
        ready_man = 1'b0;
        tick(2);
        send_frame(8'h1C, 0, 0, 1);
        check("make_held", {31'd0, evt_valid}, 32'd1);
        ready_man = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("make_popped", {31'd0, evt_valid}, 32'd0);
        wait_drain("make");

        // Prefixes and shift tracking
        send_frame(8'h12, 0, 0, 0); check_state("shift_make");
        send_frame(8'hE0, 0, 0, 0); send_frame(8'h12, 0, 0, 0); check_state("fake_shift");
        send_frame(8'hF0, 0, 0, 0); send_frame(8'h12, 0, 0, 0); check_state("shift_break");
        send_frame(8'hE0, 0, 0, 0); send_frame(8'hF0, 0, 0, 0); send_frame(8'h75, 0, 0, 0);
        check_state("ext_break");
        send_frame(8'h59, 0, 0, 0); check_state("rshift_make");
        wait_drain("prefix");

        // Framing errors
        send_frame(8'h1C, 1, 0, 0); check_state("par_err");
        send_frame(8'h1C, 0, 1, 0); check_state("stop_err");
        send_frame(8'h1C, 1, 1, 0); check_state("both_err");
        send_frame(8'h29, 0, 0, 0); check_state("after_err");
        wait_drain("err");

        // Timeout of a partial frame
        reset_dut();
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        check("to_busy", {31'd0, busy}, 32'd1);
        tick(TC + 10);
        m_err++;
        check_state("timeout");
        check("to_valid", {31'd0, evt_valid}, 32'd0);
        send_frame(8'h5A, 0, 0, 0);
        wait_drain("after_to");
        check_state("after_to");

        // FIFO full and overflow
        ready_man = 1'b0;
        tick(3);
        send_frame(8'h16, 0, 0, 0); send_frame(8'h1E, 0, 0, 0); send_frame(8'h26, 0, 0, 0);
        send_frame(8'h25, 0, 0, 0); send_frame(8'h2E, 0, 0, 0);
        check_state("full");
        check("full_valid", {31'd0, evt_valid}, 32'd1);
        ready_man = 1'b1;
        wait_drain("full");
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        m_ovf = 0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Randomised traffic with random back-pressure
        rnd_mode = 1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'h12;
                3: b = 8'h59;
                default: begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
                end
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 14) == 0);
            send_frame(b, bp, bs, 0);
            check_state("rnd");
        end
        rnd_mode = 0;
        ready_man = 1'b1;
        wait_drain("rnd");

        // Error counter saturation
        for (int i = 0; i < 10; i++) begin
            bp = ($urandom_range(0, 1) == 1);
            send_frame(8'($urandom_range(0, 255)), bp, !bp, 0);
        end
        check_state("sat");
        check("sat_err", {29'd0, err_count}, ERR_MAX);

        tick(20);
        check("end_valid", {31'd0, evt_valid}, 32'd0);
        check("end_queue", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
